// File: rtl/tie_bank_pkg.sv
// Shared types and helpers for the programmable tie bank.
package tie_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    FULL = 2'b10
  } tie_state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tie_shift_reg.sv
// Shadow shift register plus beat counter for the tie bank.
// A clear on the same edge as an accept wins: the beat is dropped and the
// shadow contents hold.
module tie_shift_reg
  import tie_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_shr,
  output logic             o_full,
  output logic             o_last
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_shr_next;

  generate
    if (WIDTH == 1) begin : g_single
      assign w_shr_next = i_bit;
    end else begin : g_multi
      assign w_shr_next = {r_shr[WIDTH-2:0], i_bit};
    end
  endgenerate

  // Beat counter: cleared on commit, advanced on each accepted beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_accept) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Shadow register: shifts MSB-first on accepted beats, otherwise holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shr <= '0;
    end else if (i_accept && !i_clear) begin
      r_shr <= w_shr_next;
    end
  end

  assign o_shr  = r_shr;
  assign o_full = (r_count == FULL_CNT);
  assign o_last = (r_count == LAST_CNT);

endmodule

// File: rtl/tie_bank_ctrl.sv
// Serially programmable bank of registered tie outputs. Bits are collected
// in a shadow register and applied to X atomically on COMMIT once a full
// word has been loaded; a COMMIT on a partial load sets the sticky ERR.
module tie_bank_ctrl
  import tie_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             OT,
  input  logic             SVALID,
  output logic             SREADY,
  input  logic             COMMIT,
  output logic [WIDTH-1:0] X,
  output logic             BUSY,
  output logic             ERR
);

  tie_state_t       r_state;
  tie_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_x;
  logic             r_err;
  logic [WIDTH-1:0] w_shr;
  logic             w_full;
  logic             w_last;
  logic             w_accept;
  logic             w_commit_ok;
  logic             w_commit_err;

  // COMMIT always takes precedence over a beat in the same cycle.
  assign w_accept     = SVALID & SREADY & ~COMMIT;
  assign w_commit_ok  = COMMIT & w_full;
  assign w_commit_err = COMMIT & ~w_full;

  tie_shift_reg #(.WIDTH(WIDTH)) u_shr (
    .i_clk    (CK),
    .i_rst    (RST),
    .i_accept (w_accept),
    .i_bit    (OT),
    .i_clear  (COMMIT),
    .o_shr    (w_shr),
    .o_full   (w_full),
    .o_last   (w_last)
  );

  // Load-progress state register.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; SREADY/BUSY depend on state only.
  always_comb begin
    w_state_nxt = r_state;
    SREADY      = (r_state != FULL);
    BUSY        = (r_state != IDLE);
    case (r_state)
      IDLE, LOAD: begin
        if (COMMIT) begin
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_state_nxt = w_last ? FULL : LOAD;
        end
      end
      FULL: begin
        if (COMMIT) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tie outputs: updated only by a commit of a complete load.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_x <= DEFAULT;
    end else if (w_commit_ok) begin
      r_x <= w_shr;
    end
  end

  // Sticky error: premature commit; cleared only by reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_commit_err) begin
      r_err <= 1'b1;
    end
  end

  assign X   = r_x;
  assign ERR = r_err;

endmodule

// File: tb/tb_tie_bank_ctrl.sv
// Scoreboard bench for tie_bank_ctrl: one WIDTH=8 instance and one WIDTH=1,
// DEFAULT=1 instance. Stimulus pushes expected observations; a monitor pops
// and compares on the falling edge whenever a probe is raised.
module tb_tie_bank_ctrl;

  typedef struct {
    logic [7:0] x;
    logic       busy;
    logic       err;
    logic       srdy;
    string      nm;
  } exp_t;

  logic       ck = 1'b0;
  logic       rst;
  logic       ot8, sv8, cm8;
  logic       ot1, sv1, cm1;
  logic       srdy8, busy8, err8;
  logic       srdy1, busy1, err1;
  logic [7:0] x8;
  logic [0:0] x1;
  logic       probe8, probe1;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  tie_bank_ctrl #(.WIDTH(8), .DEFAULT(8'h00)) u_dut8 (
    .CK(ck), .RST(rst), .OT(ot8), .SVALID(sv8), .SREADY(srdy8),
    .COMMIT(cm8), .X(x8), .BUSY(busy8), .ERR(err8)
  );

  tie_bank_ctrl #(.WIDTH(1), .DEFAULT(1'b1)) u_dut1 (
    .CK(ck), .RST(rst), .OT(ot1), .SVALID(sv1), .SREADY(srdy1),
    .COMMIT(cm1), .X(x1), .BUSY(busy1), .ERR(err1)
  );

  always #5 ck = ~ck;

  // Monitor: compare DUT outputs against the next queued expectation.
  always @(negedge ck) begin
    if (probe8 || probe1) begin
      exp_t        e;
      logic [10:0] act;
      logic [10:0] req;
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard_empty: probe raised with no expectation queued");
      end else begin
        e = q.pop_front();
        if (probe8) act = {x8, busy8, err8, srdy8};
        else        act = {7'b0, x1, busy1, err1, srdy1};
        req = {e.x, e.busy, e.err, e.srdy};
        if (act !== req) begin
          errors = errors + 1;
          $display("FAIL %s: got X=%h BUSY=%b ERR=%b SREADY=%b, want X=%h BUSY=%b ERR=%b SREADY=%b",
                   e.nm, act[10:3], act[2], act[1], act[0], e.x, e.busy, e.err, e.srdy);
        end
      end
    end
  end

  // One clock of stimulus on the WIDTH=8 instance.
  task automatic d8(input logic r, input logic v, input logic b, input logic c);
    rst = r; sv8 = v; ot8 = b; cm8 = c;
    sv1 = 1'b0; ot1 = 1'b0; cm1 = 1'b0;
    @(posedge ck); #1;
    probe8 = 1'b0; probe1 = 1'b0;
  endtask

  // One clock of stimulus on the WIDTH=1 instance.
  task automatic d1(input logic v, input logic b, input logic c);
    rst = 1'b0; sv8 = 1'b0; ot8 = 1'b0; cm8 = 1'b0;
    sv1 = v; ot1 = b; cm1 = c;
    @(posedge ck); #1;
    probe8 = 1'b0; probe1 = 1'b0;
  endtask

  task automatic idle();
    d8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load8(input logic [7:0] val, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      d8(1'b0, 1'b1, val[i], 1'b0);
      if (gaps) idle();
    end
  endtask

  task automatic commit8();
    d8(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk8(input logic [7:0] x, input logic busy, input logic err,
                      input logic srdy, input string nm);
    exp_t e;
    e.x = x; e.busy = busy; e.err = err; e.srdy = srdy; e.nm = nm;
    q.push_back(e);
    probe8 = 1'b1;
  endtask

  task automatic chk1(input logic x, input logic busy, input logic err,
                      input logic srdy, input string nm);
    exp_t e;
    e.x = {7'b0, x}; e.busy = busy; e.err = err; e.srdy = srdy; e.nm = nm;
    q.push_back(e);
    probe1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1; probe8 = 1'b0; probe1 = 1'b0;
    sv8 = 1'b0; ot8 = 1'b0; cm8 = 1'b0;
    sv1 = 1'b0; ot1 = 1'b0; cm1 = 1'b0;
    d8(1'b1, 1'b0, 1'b0, 1'b0);
    d8(1'b1, 1'b0, 1'b0, 1'b0);
    chk8(8'h00, 1'b0, 1'b0, 1'b1, "reset8");
    idle();
    chk1(1'b1, 1'b0, 1'b0, 1'b1, "reset1");
    idle();

    // 1,0,1,1,0,0,1,0 -> B2
    v = 8'hB2;
    for (int i = 7; i >= 3; i--) d8(1'b0, 1'b1, v[i], 1'b0);
    chk8(8'h00, 1'b1, 1'b0, 1'b1, "busy_mid_load");
    for (int i = 2; i >= 0; i--) d8(1'b0, 1'b1, v[i], 1'b0);
    chk8(8'h00, 1'b1, 1'b0, 1'b0, "full_b2");
    commit8();
    chk8(8'hB2, 1'b0, 1'b0, 1'b1, "commit_b2");
    idle();

    // Extra beats while full are ignored
    load8(8'h5C, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    chk8(8'hB2, 1'b1, 1'b0, 1'b0, "overflow_held");
    commit8();
    chk8(8'h5C, 1'b0, 1'b0, 1'b1, "overflow_commit");
    idle();

    // Premature commit, then sticky error across a good load
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b0);
    commit8();
    chk8(8'h5C, 1'b0, 1'b1, 1'b1, "err_partial");
    load8(8'h0F, 1'b0);
    commit8();
    chk8(8'h0F, 1'b0, 1'b1, 1'b1, "err_sticky");
    idle();

    // Reset on beat 5 discards the load and clears ERR
    v = 8'hA5;
    for (int i = 7; i >= 4; i--) d8(1'b0, 1'b1, v[i], 1'b0);
    d8(1'b1, 1'b1, v[3], 1'b1);
    chk8(8'h00, 1'b0, 1'b0, 1'b1, "rst_mid_load");
    load8(8'hA5, 1'b0);
    commit8();
    chk8(8'hA5, 1'b0, 1'b0, 1'b1, "commit_a5");
    idle();

    // Commit on the same edge as beat 8: beat dropped, error raised
    for (int i = 0; i < 7; i++) d8(1'b0, 1'b1, 1'b1, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b1);
    chk8(8'hA5, 1'b0, 1'b1, 1'b1, "commit_on_beat8");
    load8(8'h3C, 1'b0);
    chk8(8'hA5, 1'b1, 1'b1, 1'b0, "count_restarted");
    commit8();
    chk8(8'h3C, 1'b0, 1'b1, 1'b1, "after_drop");
    idle();

    // Commit in FULL with SVALID high: no beat taken
    load8(8'h81, 1'b0);
    d8(1'b0, 1'b1, 1'b1, 1'b1);
    chk8(8'h81, 1'b0, 1'b1, 1'b1, "commit_with_valid");
    idle();

    // Gaps between every beat
    load8(8'h6D, 1'b1);
    chk8(8'h81, 1'b1, 1'b1, 1'b0, "gapped_full");
    commit8();
    chk8(8'h6D, 1'b0, 1'b1, 1'b1, "gapped_commit");
    idle();

    // WIDTH=1 instance
    d1(1'b1, 1'b0, 1'b0);
    chk1(1'b1, 1'b1, 1'b0, 1'b0, "w1_full");
    d1(1'b0, 1'b0, 1'b1);
    chk1(1'b0, 1'b0, 1'b0, 1'b1, "w1_commit0");
    d1(1'b1, 1'b1, 1'b0);
    d1(1'b0, 1'b0, 1'b1);
    chk1(1'b1, 1'b0, 1'b0, 1'b1, "w1_commit1");
    d1(1'b0, 1'b0, 1'b1);
    chk1(1'b1, 1'b0, 1'b1, 1'b1, "w1_err");
    idle();
    idle();

    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
